// File: rtl/lc3b_types.sv
// Shared types for the write-combining buffer slice.
// Line, mask and tag widths plus the buffer state encoding.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_mask16;
    typedef logic [11:0]  lc3b_tag;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic [1:0] {
        WCB_EMPTY,
        WCB_HOLD,
        WCB_DRAIN
    } wcb_state_t;

    localparam lc3b_mask16 WCB_FULL_MASK = 16'hFFFF;

endpackage

// File: rtl/line_byte_merge.sv
// Byte-granular merge of a replicated store word into a 16-byte line.
// Bytes whose mask bit is clear keep their old value.
module line_byte_merge
    import lc3b_types::*;
(
    input  lc3b_line   old_line,
    input  lc3b_line   word_rep,
    input  lc3b_mask16 mask,
    output lc3b_line   merged_line
);

    always_comb begin
        merged_line = old_line;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) merged_line[8*i +: 8] = word_rep[8*i +: 8];
        end
    end

endmodule

// File: rtl/write_coalesce_buf.sv
// Single-line write-combining buffer between the mask generator and pmem.
// Define WCB_IDLE_DRAIN_EN to auto-drain after IDLE_LIMIT idle HOLD cycles.
module write_coalesce_buf
    import lc3b_types::*;
#(
    parameter int IDLE_LIMIT = 16
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_write,
    input  logic [15:0]  cpu_address,
    input  logic [15:0]  cpu_wdata,
    input  logic [15:0]  sel_mask,
    input  logic         flush,
    output logic         cpu_resp,
    output logic         flush_done,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    output logic [15:0]  pmem_byte_mask,
    input  logic         pmem_resp,
    output logic         buf_busy
);

    wcb_state_t state_q, state_nx;
    lc3b_tag    tag_q, tag_nx;
    lc3b_mask16 mask_q, mask_nx;
    lc3b_line   data_q, data_nx, merged;
    logic       fd_q, fd_nx;
    logic       accept;
    logic       tag_hit;
    logic       unused_addr;

`ifdef WCB_IDLE_DRAIN_EN
    logic [7:0] idle_q, idle_nx;
`else
    logic unused_cfg;
    assign unused_cfg = ^IDLE_LIMIT;
`endif

    assign unused_addr = ^cpu_address[3:0];
    assign tag_hit     = (cpu_address[15:4] == tag_q);

    line_byte_merge u_merge (
        .old_line    (data_q),
        .word_rep    ({8{cpu_wdata}}),
        .mask        (sel_mask),
        .merged_line (merged)
    );

    always_comb begin
        state_nx = state_q;
        tag_nx   = tag_q;
        mask_nx  = mask_q;
        data_nx  = data_q;
        fd_nx    = 1'b0;
        accept   = 1'b0;
`ifdef WCB_IDLE_DRAIN_EN
        idle_nx  = '0;
`endif
        unique case (state_q)
            WCB_EMPTY: begin
                if (cpu_write) begin
                    accept = 1'b1;
                    if (sel_mask != '0) begin
                        tag_nx   = cpu_address[15:4];
                        mask_nx  = sel_mask;
                        data_nx  = merged;
                        state_nx = WCB_HOLD;
                    end
                end
                // A flush that coincides with an allocation is served by the drain
                fd_nx = flush && !(cpu_write && sel_mask != '0);
            end
            WCB_HOLD: begin
                if (flush) begin
                    state_nx = WCB_DRAIN;
                end else if (cpu_write && tag_hit) begin
                    accept  = 1'b1;
                    data_nx = merged;
                    mask_nx = mask_q | sel_mask;
                    if ((mask_q | sel_mask) == WCB_FULL_MASK)
                        state_nx = WCB_DRAIN;
                end else if (cpu_write) begin
                    state_nx = WCB_DRAIN;
                end else begin
`ifdef WCB_IDLE_DRAIN_EN
                    if (idle_q == 8'(IDLE_LIMIT - 1))
                        state_nx = WCB_DRAIN;
                    else
                        idle_nx = idle_q + 8'd1;
`endif
                end
            end
            WCB_DRAIN: begin
                if (pmem_resp) begin
                    mask_nx  = '0;
                    state_nx = WCB_EMPTY;
                    fd_nx    = flush;
                end
            end
            default: state_nx = WCB_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WCB_EMPTY;
            tag_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_nx;
            tag_q   <= tag_nx;
            mask_q  <= mask_nx;
            data_q  <= data_nx;
            fd_q    <= fd_nx;
        end
    end

`ifdef WCB_IDLE_DRAIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_nx;
    end
`endif

    // Outputs read 0 while reset is held, even with a store pending
    assign cpu_resp       = accept & rst_n;
    assign flush_done     = fd_q;
    assign pmem_write     = (state_q == WCB_DRAIN);
    assign pmem_address   = {tag_q, 4'h0};
    assign pmem_wdata     = data_q;
    assign pmem_byte_mask = mask_q;
    assign buf_busy       = (state_q != WCB_EMPTY);

endmodule

// File: tb/tb_write_coalesce_buf.sv
// Directed bench for write_coalesce_buf with a drain scoreboard.
// Build with WCB_IDLE_DRAIN_EN to exercise the idle auto-drain path.
module tb_write_coalesce_buf;
    import lc3b_types::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_write;
    logic [15:0]  cpu_address;
    logic [15:0]  cpu_wdata;
    logic [15:0]  sel_mask;
    logic         flush;
    logic         cpu_resp;
    logic         flush_done;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [15:0]  pmem_byte_mask;
    logic         pmem_resp;
    logic         buf_busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0]  addr;
        logic [15:0]  mask;
        logic [127:0] data;
    } drain_t;

    drain_t exp_q[$];

    always #5 clk = ~clk;

`ifdef WCB_IDLE_DRAIN_EN
    write_coalesce_buf #(.IDLE_LIMIT(4)) dut (
`else
    write_coalesce_buf dut (
`endif
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_wdata      (cpu_wdata),
        .sel_mask       (sel_mask),
        .flush          (flush),
        .cpu_resp       (cpu_resp),
        .flush_done     (flush_done),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_byte_mask (pmem_byte_mask),
        .pmem_resp      (pmem_resp),
        .buf_busy       (buf_busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] byte_en(input logic [15:0] m);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] m, input logic exp_resp,
                         input string tag);
        cpu_write   = 1'b1;
        cpu_address = a;
        cpu_wdata   = d;
        sel_mask    = m;
        @(negedge clk);
        chk(tag, cpu_resp, exp_resp);
        cyc();
        if (exp_resp) cpu_write = 1'b0;
    endtask

    // Called just after a posedge; returns on the negedge after the drain ends.
    task automatic wait_drain(input int lat, input logic exp_fd,
                              input string tag);
        drain_t e;
        int n = 0;
        @(negedge clk);
        while (pmem_write !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_pmem_write"}, pmem_write, 1'b1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb observed=drain expected=none", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_addr"}, pmem_address, e.addr);
            chk({tag, "_mask"}, pmem_byte_mask, e.mask);
            chk({tag, "_data"}, pmem_wdata & byte_en(e.mask),
                e.data & byte_en(e.mask));
            chk({tag, "_resp0"}, cpu_resp, 1'b0);
            for (int k = 1; k < lat; k++) @(negedge clk);
            chk({tag, "_hold_mask"}, pmem_byte_mask, e.mask);
            chk({tag, "_hold_addr"}, pmem_address, e.addr);
        end
        cyc();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk({tag, "_pw_at_resp"}, pmem_write, 1'b1);
        cyc();
        pmem_resp = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        chk({tag, "_pw_fall"}, pmem_write, 1'b0);
        chk({tag, "_fd"}, flush_done, exp_fd);
        chk({tag, "_busy"}, buf_busy, 1'b0);
    endtask

    initial begin
        drain_t e;
        logic [127:0] line;

        rst_n = 1'b0;
        cpu_write = 1'b0;
        cpu_address = '0;
        cpu_wdata = '0;
        sel_mask = '0;
        flush = 1'b0;
        pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_busy", buf_busy, 1'b0);
        chk("rst_addr", pmem_address, 16'h0);
        chk("rst_mask", pmem_byte_mask, 16'h0);
        chk("rst_data", pmem_wdata, 128'h0);
        chk("rst_fd", flush_done, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single store then flush
        store(16'h1232, 16'hBEEF, 16'h000C, 1'b1, "t1_resp");
        @(negedge clk);
        chk("t1_busy", buf_busy, 1'b1);
        chk("t1_no_drain", pmem_write, 1'b0);
        line = '0;
        line[31:16] = 16'hBEEF;
        e.addr = 16'h1230; e.mask = 16'h000C; e.data = line;
        exp_q.push_back(e);
        cyc();
        flush = 1'b1;
        cyc();
        wait_drain(3, 1'b1, "t1");
        cyc();
        chk("t1_fd_pulse", flush_done, 1'b0);

        // Eight word stores fill the line
        line = '0;
        for (int k = 0; k < 8; k++) begin
            logic [15:0] d;
            d = 16'hA000 + 16'(k) * 16'h0111;
            line[16*k +: 16] = d;
            store(16'h4000 + 16'(2*k), d, 16'h0003 << (2*k), 1'b1,
                  "t2_resp");
        end
        e.addr = 16'h4000; e.mask = 16'hFFFF; e.data = line;
        exp_q.push_back(e);
        @(negedge clk);
        chk("t2_auto_drain", pmem_write, 1'b1);
        cyc();
        wait_drain(2, 1'b0, "t2");
        cyc();

        // Conflicting tag forces drain, store accepted afterwards
        store(16'h2000, 16'h00AA, 16'h0001, 1'b1, "t3_first");
        line = '0;
        line[7:0] = 8'hAA;
        e.addr = 16'h2000; e.mask = 16'h0001; e.data = line;
        exp_q.push_back(e);
        cpu_write = 1'b1;
        cpu_address = 16'h3004;
        cpu_wdata = 16'h5566;
        sel_mask = 16'h0010;
        @(negedge clk);
        chk("t3_conflict_resp", cpu_resp, 1'b0);
        cyc();
        wait_drain(2, 1'b0, "t3");
        chk("t3_accept_after", cpu_resp, 1'b1);
        cyc();
        cpu_write = 1'b0;
        line = '0;
        line[39:32] = 8'h66;
        e.addr = 16'h3000; e.mask = 16'h0010; e.data = line;
        exp_q.push_back(e);
        flush = 1'b1;
        cyc();
        wait_drain(1, 1'b1, "t3b");
        cyc();

        // Empty mask store in EMPTY
        store(16'h7770, 16'h1111, 16'h0000, 1'b1, "t4_resp");
        @(negedge clk);
        chk("t4_busy", buf_busy, 1'b0);
        cyc();

        // Flush beats a same-tag store
        store(16'h5000, 16'h1234, 16'h0003, 1'b1, "t5_first");
        line = '0;
        line[15:0] = 16'h1234;
        e.addr = 16'h5000; e.mask = 16'h0003; e.data = line;
        exp_q.push_back(e);
        cpu_write = 1'b1;
        cpu_address = 16'h5002;
        cpu_wdata = 16'h7788;
        sel_mask = 16'h000C;
        flush = 1'b1;
        @(negedge clk);
        chk("t5_flush_prio", cpu_resp, 1'b0);
        cyc();
        wait_drain(2, 1'b1, "t5");
        chk("t5_accept_after", cpu_resp, 1'b1);
        cyc();
        cpu_write = 1'b0;
        line = '0;
        line[31:16] = 16'h7788;
        e.addr = 16'h5000; e.mask = 16'h000C; e.data = line;
        exp_q.push_back(e);
        flush = 1'b1;
        cyc();
        wait_drain(1, 1'b1, "t5b");
        cyc();

        // Idle behaviour in HOLD
        store(16'h6000, 16'h00CD, 16'h0001, 1'b1, "t6_resp");
`ifdef WCB_IDLE_DRAIN_EN
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            chk("t6_idle_wait", pmem_write, 1'b0);
            cyc();
        end
        line = '0;
        line[7:0] = 8'hCD;
        e.addr = 16'h6000; e.mask = 16'h0001; e.data = line;
        exp_q.push_back(e);
        @(negedge clk);
        chk("t6_idle_drain", pmem_write, 1'b1);
        cyc();
        wait_drain(1, 1'b0, "t6");
        cyc();
`else
        repeat (40) cyc();
        @(negedge clk);
        chk("t6_hold_pw", pmem_write, 1'b0);
        chk("t6_hold_busy", buf_busy, 1'b1);
        line = '0;
        line[7:0] = 8'hCD;
        e.addr = 16'h6000; e.mask = 16'h0001; e.data = line;
        exp_q.push_back(e);
        cyc();
        flush = 1'b1;
        cyc();
        wait_drain(1, 1'b1, "t6");
        cyc();
`endif

        // Reset in the middle of a drain
        store(16'h7000, 16'h9999, 16'h0002, 1'b1, "t7_resp");
        flush = 1'b1;
        cyc();
        @(negedge clk);
        chk("t7_in_drain", pmem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_pw", pmem_write, 1'b0);
        chk("t7_rst_busy", buf_busy, 1'b0);
        chk("t7_rst_mask", pmem_byte_mask, 16'h0);
        flush = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        chk("t7_after_pw", pmem_write, 1'b0);
        chk("t7_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/write_coalesce_buf.md
Name: write_coalesce_buf

Overview:
- Single-line write-combining buffer sitting directly downstream of the byte-lane mask generator in the cache write path.
- Consumes the 16-bit per-byte lane mask together with the store address and data.
- Merges successive stores to the same 16-byte line into a 128-bit holding register with a per-byte valid mask.
- Drains the merged line to physical memory through a req/resp handshake on tag change, flush, or full mask.

Parameters:
IDLE_LIMIT, 16, idle cycles in HOLD before auto-drain; used only when WCB_IDLE_DRAIN_EN is defined; legal range 1..255.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cpu_write  in  1  store request; held by requester until cpu_resp
cpu_address  in  16  store byte address; [15:4] tag, [3:1] word slot
cpu_wdata  in  16  lane-aligned store data (lc3b_word)
sel_mask  in  16  per-byte write mask for the 16-byte line, from the mask generator
flush  in  1  level request to drain the buffer
cpu_resp  out  1  store accepted this cycle (combinational)
flush_done  out  1  one-cycle pulse: buffer empty after a flush request
pmem_write  out  1  line write request to memory
pmem_address  out  16  {tag, 4'h0}
pmem_wdata  out  128  merged line data
pmem_byte_mask  out  16  valid-byte mask of pmem_wdata
pmem_resp  in  1  memory write complete
buf_busy  out  1  state != EMPTY

Behaviour:
- Reset (rst_n low, async): state=EMPTY, mask=0, tag=0, data=0, idle count=0. All outputs 0.
- Merge rule: replicate cpu_wdata into all 8 word slots. For each byte i with sel_mask[i]=1: data byte i <= replicated byte i and mask[i] <= 1. Other bytes are unchanged.
- State EMPTY:
  - cpu_write with sel_mask!=0: cpu_resp=1, tag<=cpu_address[15:4], mask<=sel_mask, merge, go HOLD.
  - cpu_write with sel_mask==0: cpu_resp=1, no state change.
  - flush: flush_done pulses the next cycle.
- State HOLD:
  - flush has priority over everything: cpu_resp=0, go DRAIN.
  - Otherwise, cpu_write with the same tag: cpu_resp=1, merge, mask |= sel_mask. If the resulting mask==16'hFFFF, go DRAIN; else stay.
  - Otherwise, cpu_write with a different tag: cpu_resp=0, go DRAIN. The store is held by the requester and accepted in EMPTY after the drain.
- State DRAIN:
  - pmem_write=1; address, data and mask are held stable until pmem_resp.
  - cpu_resp=0 throughout.
  - On pmem_resp: mask<=0, go EMPTY. If flush is high that cycle, flush_done pulses the next cycle.
  - A cpu_write coincident with pmem_resp is not accepted that cycle.
- Latency:
  - Store hit/allocate: 0 cycles, cpu_resp in the request cycle.
  - Conflicting store: 1 cycle to DRAIN, plus memory latency, plus 1 cycle in EMPTY.
- pmem_write deasserts the cycle after pmem_resp. No back-to-back drains.
- Reset during DRAIN drops the line, and pmem_write falls immediately.

Optional Feature:
- WCB_IDLE_DRAIN_EN defined:
  - An 8-bit idle counter increments each HOLD cycle without an accepted store.
  - The counter clears on an accepted store or on leaving HOLD.
  - When count reaches IDLE_LIMIT-1 in HOLD, go DRAIN the next cycle.
- Undefined: no counter; HOLD persists indefinitely.

Decomposition:
- lc3b_types package:
  - lc3b_line (128-bit)
  - lc3b_mask16 (16-bit)
  - lc3b_tag (12-bit)
  - enum wcb_state_t {WCB_EMPTY, WCB_HOLD, WCB_DRAIN}
  - constant WCB_FULL_MASK = 16'hFFFF
- One combinational sub-module, line_byte_merge:
  - Inputs: old line, replicated word, mask.
  - Output: merged line.

Test Plan:
- Reset, then store addr 16'h1232, data 16'hBEEF, mask 16'h000C → cpu_resp same cycle. Then flush → pmem_address 16'h1230, bytes 2..3 = EF,BE, pmem_byte_mask 16'h000C; pmem_resp after 3 cycles → flush_done pulse, buf_busy=0.
- Eight word stores 16'h4000..16'h400E, each with mask 16'h0003<<addr[3:0], no flush → after the 8th, DRAIN entered automatically with pmem_byte_mask 16'hFFFF.
- Store 16'h2000 mask 16'h0001, then store 16'h3004 → cpu_resp=0 and drain of 16'h2000. After pmem_resp: store accepted next cycle, buf tag 16'h300, mask 16'h0010.
- Store with sel_mask 16'h0000 in EMPTY → cpu_resp=1, buf_busy stays 0.
- In HOLD, flush and a same-tag cpu_write in the same cycle → cpu_resp=0, DRAIN with the old mask. Write accepted after pmem_resp.
- rst_n low mid-DRAIN → pmem_write=0 immediately, buf_busy=0. With WCB_IDLE_DRAIN_EN and IDLE_LIMIT=4: one store, then idle → pmem_write rises 5 cycles after the accept.
